apb_req_arbiter: RTL and testbench
==================================

# apb_req_arbiter

Round-robin arbiter that shares the single `apb_master` request front-end (`trnsfr`, `wr`, `address`, `data_in`, `dsel`, `ready`, `data_out`) between `NREQ` local requesters. It grants one requester at a time and sequences the `trnsfr` pulse in step with the master's IDLE/SETUP/ACCESS protocol. It returns the read data and a completion pulse to the granted requester. It sits between the bridge's requester ports and `apb_master`.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `ADDR_W`, default `` `ADDR_WIDTH ``: address width.
- `DATA_W`, default `` `DATA_WIDTH ``: data width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_i` in NREQ: per-requester request level.
- `wr_i` in NREQ: 1 = write, 0 = read.
- `addr_i` in NREQ×ADDR_W: byte address.
- `wdata_i` in NREQ×DATA_W: write data, right-aligned.
- `dsel_i` in NREQ×2: size select; 0 = word, 1 = half, 2 = byte.
- `gnt_o` out NREQ: one-hot one-cycle pulse; the command has been accepted.
- `done_o` out NREQ: one-hot one-cycle pulse; the transfer is complete.
- `rdata_o` out DATA_W: read data, valid while `done_o` is nonzero, otherwise 0.
- `m_trnsfr` out 1: drives the master's `trnsfr`.
- `m_wr`, `m_address`, `m_data_in`, `m_dsel` out: command to the master, muxed from the owner.
- `m_ready` in 1: the master's `ready`.
- `m_data_out` in DATA_W: the master's `data_out`.

## Operation
- FSM states:
  - ARB_IDLE: no transfer in progress.
  - ARB_ISSUE: `m_trnsfr`=1; the master is in IDLE and captures the command.
  - ARB_SETUP: the master is in SETUP; `m_ready` is ignored.
  - ARB_ACCESS: waiting for `m_ready`.
- Transitions:
  - ARB_IDLE → ARB_ISSUE when any `req_i` bit is set. The winner is registered into `owner`.
  - ARB_ISSUE → ARB_SETUP.
  - ARB_SETUP → ARB_ACCESS.
  - ARB_ACCESS → ARB_IDLE on `m_ready`, or stays in ARB_ACCESS while `m_ready`=0.
- Arbitration is round-robin:
  - The `prio` pointer resets to 0.
  - The winner is the first set `req_i` bit scanning from `prio` upward, modulo NREQ.
  - On grant to requester i, `prio` becomes (i+1) mod NREQ.
- `gnt_o[owner]`=1 during ARB_ISSUE. The requester holds `req_i` and its command stable until `gnt_o`, then may drop or change them.
- A requester may withdraw `req_i` before it is granted; no grant follows.
- `m_*` command outputs are 0 in ARB_IDLE. In every other state they carry the owner's command, and are not re-sampled after ARB_ISSUE.
- On ARB_ACCESS with `m_ready`=1:
  - `rdata_o` is loaded with `m_data_out`, or 0 for writes.
  - `done_o[owner]` is set, registered, in the next cycle.
- The owner raising `req_i` again in the cycle it receives `done_o` is treated as a new request; round-robin order still applies.
- Reset mid-transfer: every output goes to 0 immediately, the FSM goes to ARB_IDLE and `prio` to 0. No `done_o` is produced for the aborted transfer.

## Timing
- Reset values: `gnt_o`, `done_o`, `rdata_o`, `m_trnsfr`, `m_wr`, `m_address`, `m_data_in`, `m_dsel` are all 0.
- Cycle sequence, request sampled in cycle 0:
  - cycle 1: ISSUE with `gnt_o`;
  - cycle 2: SETUP;
  - cycle 3: ACCESS;
  - the earliest `m_ready` is in cycle 3, giving `done_o` in cycle 4.
- Issue-to-issue spacing without back-to-back mode is at least 5 cycles: ACCESS → IDLE → ISSUE.
- `m_trnsfr` is never asserted while the master is in SETUP.

## Configuration
- `APB_ARB_B2B_EN` defined:
  - In ARB_ACCESS with `m_ready`=1 and any `req_i` pending, arbitration is combinational.
  - `m_trnsfr`=1 with the new winner's command in the same cycle. The master goes ACCESS → SETUP and captures it.
  - `gnt_o[new]` pulses in that cycle, `owner`/`prio` update, and the FSM goes to ARB_SETUP.
  - `done_o` for the previous owner still follows one cycle later.
  - Issue-to-issue spacing becomes 3 cycles.
- Undefined: no back-to-back issue; the FSM always returns to ARB_IDLE.

## Structure
- Shared package `apb_arb_pkg`:
  - state enum `arb_state_e`;
  - dsel encodings `DSEL_WORD`=0, `DSEL_HALF`=1, `DSEL_BYTE`=2;
  - `NREQ_MAX`=8.
- Widths come from `apb_arch.svh`.
- One sub-module, `rr_pick`: combinational round-robin winner selection over (`req`, `prio`), returning a one-hot result and an index.

## Test plan
- Single read: `req_i`=4'b0001, addr 0x10, dsel 0, `m_ready` high in the first ACCESS cycle, `m_data_out`=0xDEADBEEF. Required: `gnt_o[0]` in cycle 1, `m_trnsfr` only in cycle 1, `done_o[0]` in cycle 4, `rdata_o`=0xDEADBEEF.
- Contention: `req_i`=4'b1111 held. Required: grant order 0,1,2,3,0; each `gnt_o` is one-hot.
- Wait states: `m_ready` low for 3 ACCESS cycles. Required: FSM holds ARB_ACCESS, `m_*` stable, `done_o` exactly once, 1 cycle after `m_ready`.
- Withdrawal: `req_i[2]` asserted for 1 cycle while requester 0 is in ACCESS. Required: no `gnt_o[2]`; FSM returns to ARB_IDLE.
- Reset in ARB_SETUP. Required: all outputs 0 asynchronously, no `done_o`, `prio` returns to 0, so the next `req_i`=4'b1010 grants 1.
- With `APB_ARB_B2B_EN`: `req_i`=4'b0011 held. Required: `m_trnsfr` high in the ACCESS cycle with `m_ready`, `gnt_o[1]` in the same cycle, `done_o[0]` in the next cycle.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB requester arbiter.
// ADDR_WIDTH / DATA_WIDTH normally come from apb_arch.svh; fallbacks are defined here.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package apb_arb_pkg;

    localparam int NREQ_MAX = 8;

    localparam logic [1:0] DSEL_WORD = 2'd0;
    localparam logic [1:0] DSEL_HALF = 2'd1;
    localparam logic [1:0] DSEL_BYTE = 2'd2;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ISSUE  = 2'd1,
        ARB_SETUP  = 2'd2,
        ARB_ACCESS = 2'd3
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or above prio, wrapping to bit 0.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] prio,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] upper;
    logic [N-1:0] cand;

    always_comb begin
        upper = '0;
        for (int i = 0; i < N; i++) begin
            upper[i] = (i >= int'(prio));
        end
        // Requests at/above the pointer win; otherwise wrap to the lowest set bit.
        cand = ((req & upper) != '0) ? (req & upper) : req;
        gnt  = cand & (~cand + ONE);
        idx  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) begin
                idx = IW'(i);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one apb_master request front-end between NREQ requesters.
// Optional back-to-back issue from ACCESS is enabled by defining APB_ARB_B2B_EN.
//
// state      | meaning
// ARB_IDLE   | no transfer in progress, command outputs 0
// ARB_ISSUE  | m_trnsfr high, master in IDLE capturing the command
// ARB_SETUP  | master in SETUP, m_ready ignored
// ARB_ACCESS | waiting for m_ready
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int ADDR_W = `ADDR_WIDTH,
    parameter int DATA_W = `DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req_i,
    input  logic [NREQ-1:0]               wr_i,
    input  logic [NREQ-1:0][ADDR_W-1:0]   addr_i,
    input  logic [NREQ-1:0][DATA_W-1:0]   wdata_i,
    input  logic [NREQ-1:0][1:0]          dsel_i,
    output logic [NREQ-1:0]               gnt_o,
    output logic [NREQ-1:0]               done_o,
    output logic [DATA_W-1:0]             rdata_o,
    output logic                          m_trnsfr,
    output logic                          m_wr,
    output logic [ADDR_W-1:0]             m_address,
    output logic [DATA_W-1:0]             m_data_in,
    output logic [1:0]                    m_dsel,
    input  logic                          m_ready,
    input  logic [DATA_W-1:0]             m_data_out
);

    localparam int               IDX_W    = idx_width(NREQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);
    localparam logic [NREQ-1:0]  ONE      = {{(NREQ-1){1'b0}}, 1'b1};

    arb_state_e         state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   prio;
    logic [NREQ-1:0]    gnt_q;
    logic               trnsfr_q;
    logic               wr_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [1:0]         dsel_q;

    logic [NREQ-1:0]    pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [IDX_W-1:0]   next_prio;
    logic               b2b_issue;

    rr_pick #(
        .N  (NREQ),
        .IW (IDX_W)
    ) u_rr_pick (
        .req  (req_i),
        .prio (prio),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign next_prio = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;

`ifdef APB_ARB_B2B_EN
    assign b2b_issue = (state == ARB_ACCESS) && m_ready && pick_any;
`else
    assign b2b_issue = 1'b0;
`endif

    // A back-to-back issue has to reach the master in the completing ACCESS cycle,
    // so it bypasses the command registers for that one cycle.
    assign m_trnsfr  = trnsfr_q | b2b_issue;
    assign gnt_o     = gnt_q | (b2b_issue ? pick_gnt : '0);
    assign m_wr      = b2b_issue ? wr_i[pick_idx]    : wr_q;
    assign m_address = b2b_issue ? addr_i[pick_idx]  : addr_q;
    assign m_data_in = b2b_issue ? wdata_i[pick_idx] : wdata_q;
    assign m_dsel    = b2b_issue ? dsel_i[pick_idx]  : dsel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            owner    <= '0;
            prio     <= '0;
            gnt_q    <= '0;
            done_o   <= '0;
            rdata_o  <= '0;
            trnsfr_q <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            dsel_q   <= '0;
        end else begin
            gnt_q    <= '0;
            done_o   <= '0;
            rdata_o  <= '0;
            trnsfr_q <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        state    <= ARB_ISSUE;
                        owner    <= pick_idx;
                        prio     <= next_prio;
                        gnt_q    <= pick_gnt;
                        trnsfr_q <= 1'b1;
                        wr_q     <= wr_i[pick_idx];
                        addr_q   <= addr_i[pick_idx];
                        wdata_q  <= wdata_i[pick_idx];
                        dsel_q   <= dsel_i[pick_idx];
                    end
                end
                ARB_ISSUE: begin
                    state <= ARB_SETUP;
                end
                ARB_SETUP: begin
                    state <= ARB_ACCESS;
                end
                ARB_ACCESS: begin
                    if (m_ready) begin
                        done_o  <= ONE << owner;
                        rdata_o <= wr_q ? '0 : m_data_out;
                        if (b2b_issue) begin
                            state   <= ARB_SETUP;
                            owner   <= pick_idx;
                            prio    <= next_prio;
                            wr_q    <= wr_i[pick_idx];
                            addr_q  <= addr_i[pick_idx];
                            wdata_q <= wdata_i[pick_idx];
                            dsel_q  <= dsel_i[pick_idx];
                        end else begin
                            state   <= ARB_IDLE;
                            wr_q    <= 1'b0;
                            addr_q  <= '0;
                            wdata_q <= '0;
                            dsel_q  <= '0;
                        end
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: vector table, directed corner cases, random vs model.
module tb_apb_req_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b1;
    logic [NREQ-1:0]           req_i = '0;
    logic [NREQ-1:0]           wr_i = '0;
    logic [NREQ-1:0][AW-1:0]   addr_i = '0;
    logic [NREQ-1:0][DW-1:0]   wdata_i = '0;
    logic [NREQ-1:0][1:0]      dsel_i = '0;
    logic [NREQ-1:0]           gnt_o;
    logic [NREQ-1:0]           done_o;
    logic [DW-1:0]             rdata_o;
    logic                      m_trnsfr;
    logic                      m_wr;
    logic [AW-1:0]             m_address;
    logic [DW-1:0]             m_data_in;
    logic [1:0]                m_dsel;
    logic                      m_ready = 1'b0;
    logic [DW-1:0]             m_data_out = '0;

    always #5 clk = ~clk;

    apb_req_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .wr_i       (wr_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .dsel_i     (dsel_i),
        .gnt_o      (gnt_o),
        .done_o     (done_o),
        .rdata_o    (rdata_o),
        .m_trnsfr   (m_trnsfr),
        .m_wr       (m_wr),
        .m_address  (m_address),
        .m_data_in  (m_data_in),
        .m_dsel     (m_dsel),
        .m_ready    (m_ready),
        .m_data_out (m_data_out)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int prio_m   = 0;

    typedef struct {
        logic [3:0]  req;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  dsel;
        int          delay;
        logic [31:0] dout;
        int          exp_idx;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_pick(input logic [3:0] p, input int pr);
        for (int k = 0; k < NREQ; k++) begin
            if (p[(pr + k) % NREQ]) return (pr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic drive_cmds(input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] dsel);
        for (int r = 0; r < NREQ; r++) begin
            wr_i[r]    = wr;
            addr_i[r]  = addr + 32'(r) * 32'h1000;
            wdata_i[r] = wdata ^ 32'(r);
            dsel_i[r]  = dsel;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"},   64'(gnt_o), 64'h0);
        chk({tag, "_done"},  64'(done_o), 64'h0);
        chk({tag, "_rdata"}, 64'(rdata_o), 64'h0);
        chk({tag, "_trn"},   64'(m_trnsfr), 64'h0);
        chk({tag, "_wr"},    64'(m_wr), 64'h0);
        chk({tag, "_addr"},  64'(m_address), 64'h0);
        chk({tag, "_wdat"},  64'(m_data_in), 64'h0);
        chk({tag, "_dsel"},  64'(m_dsel), 64'h0);
    endtask

    task automatic apply_reset();
        req_i   = '0;
        m_ready = 1'b0;
        rst_n   = 1'b0;
        #1;
        check_all_zero("reset");
        tick();
        tick();
        rst_n  = 1'b1;
        prio_m = 0;
    endtask

    // Entered in an IDLE cycle; returns in the done cycle (FSM back in IDLE).
    task automatic do_txn(input logic [3:0] pattern, input logic [3:0] hold,
                          input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] dsel, input int delay, input logic [31:0] dout,
                          input int exp_idx, input logic [3:0] wd_mask);
        logic [3:0]  exp_oh;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        exp_oh    = 4'b1 << exp_idx;
        exp_addr  = addr + 32'(exp_idx) * 32'h1000;
        exp_wdata = wdata ^ 32'(exp_idx);
        drive_cmds(wr, addr, wdata, dsel);
        req_i      = pattern;
        m_ready    = 1'b0;
        m_data_out = 32'h0BAD_0BAD;
        tick();
        chk("issue_gnt",   64'(gnt_o), 64'(exp_oh));
        chk("issue_trn",   64'(m_trnsfr), 64'h1);
        chk("issue_addr",  64'(m_address), 64'(exp_addr));
        chk("issue_wr",    64'(m_wr), 64'(wr));
        chk("issue_wdata", 64'(m_data_in), 64'(exp_wdata));
        chk("issue_dsel",  64'(m_dsel), 64'(dsel));
        chk("issue_done",  64'(done_o), 64'h0);
        chk("issue_rdata", 64'(rdata_o), 64'h0);
        req_i   = hold & ~exp_oh;
        drive_cmds(~wr, ~addr, ~wdata, 2'd3);
        m_ready = 1'b1;
        tick();
        chk("setup_gnt",  64'(gnt_o), 64'h0);
        chk("setup_trn",  64'(m_trnsfr), 64'h0);
        chk("setup_addr", 64'(m_address), 64'(exp_addr));
        for (int k = 0; k <= delay; k++) begin
            tick();
            chk("acc_done",  64'(done_o), 64'h0);
            chk("acc_gnt",   64'(gnt_o), 64'h0);
            chk("acc_trn",   64'(m_trnsfr), 64'h0);
            chk("acc_addr",  64'(m_address), 64'(exp_addr));
            chk("acc_wdata", 64'(m_data_in), 64'(exp_wdata));
            chk("acc_wr",    64'(m_wr), 64'(wr));
            if (k == 0) req_i = req_i | wd_mask;
            if (k == 1) req_i = req_i & ~wd_mask;
            m_ready    = (k == delay);
            m_data_out = (k == delay) ? dout : 32'h0BAD_0BAD;
        end
        req_i = req_i & ~wd_mask;
        tick();
        chk("done_oh",    64'(done_o), 64'(exp_oh));
        chk("done_rdata", 64'(rdata_o), wr ? 64'h0 : 64'(dout));
        chk("done_trn",   64'(m_trnsfr), 64'h0);
        chk("done_addr",  64'(m_address), 64'h0);
        chk("done_gnt",   64'(gnt_o), 64'h0);
        m_ready = 1'b0;
    endtask

    initial begin
        logic [3:0] pending;
        logic [3:0] nb;
        int         w;
        int         order [5];

        vecs[0] = '{4'b0001, 1'b0, 32'h10, 32'h0,         2'd0, 0, 32'hDEADBEEF, 0};
        vecs[1] = '{4'b0101, 1'b1, 32'h24, 32'h12345678,  2'd2, 0, 32'h77777777, 2};
        vecs[2] = '{4'b0011, 1'b0, 32'h30, 32'h0,         2'd0, 1, 32'hA5A50001, 0};
        vecs[3] = '{4'b1000, 1'b0, 32'h44, 32'h0,         2'd1, 3, 32'hCAFEF00D, 3};
        vecs[4] = '{4'b1110, 1'b1, 32'h58, 32'h0F0F0F0F,  2'd1, 2, 32'h13579BDF, 1};
        vecs[5] = '{4'b0010, 1'b0, 32'h6C, 32'h0,         2'd2, 0, 32'h11223344, 1};
        order   = '{0, 1, 2, 3, 0};

        #2;
        apply_reset();

        for (int v = 0; v < 6; v++) begin
            do_txn(vecs[v].req, 4'b0, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].dsel,
                   vecs[v].delay, vecs[v].dout, vecs[v].exp_idx, 4'b0);
            tick();
            chk("idle_gnt",   64'(gnt_o), 64'h0);
            chk("idle_done",  64'(done_o), 64'h0);
            chk("idle_rdata", 64'(rdata_o), 64'h0);
            chk("idle_trn",   64'(m_trnsfr), 64'h0);
        end

        // Withdrawal: requester 2 pulses while requester 0 sits in ACCESS.
        do_txn(4'b0001, 4'b0, 1'b0, 32'h80, 32'h0, 2'd0, 2, 32'h5555AAAA, 0, 4'b0100);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("wd_gnt", 64'(gnt_o), 64'h0);
            chk("wd_trn", 64'(m_trnsfr), 64'h0);
        end

        // Reset during SETUP: pointer sits at 3 before reset, so 1010 tells 0 from 3.
        drive_cmds(1'b0, 32'h90, 32'h0, 2'd0);
        req_i = 4'b0100;
        tick();
        chk("rs_gnt", 64'(gnt_o), 64'b0100);
        req_i = '0;
        tick();
        chk("rs_setup_trn", 64'(m_trnsfr), 64'h0);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        m_ready    = 1'b1;
        m_data_out = 32'hFFFF0000;
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rs_no_done", 64'(done_o), 64'h0);
            chk("rs_no_gnt",  64'(gnt_o), 64'h0);
        end
        m_ready = 1'b0;
        do_txn(4'b1010, 4'b0, 1'b0, 32'hA0, 32'h0, 2'd0, 0, 32'h01020304, 1, 4'b0);
        tick();

`ifndef APB_ARB_B2B_EN
        // Contention: all four held, winners re-request in their done cycle.
        apply_reset();
        for (int g = 0; g < 5; g++) begin
            do_txn(4'hF, 4'hF, g[0], 32'h100 + 32'(g) * 4, 32'hAB00_0000 + 32'(g), 2'd0,
                   0, 32'h6000_0000 + 32'(g), order[g], 4'b0);
        end
        req_i = '0;
        tick();
        tick();

        // Random arrivals checked against the round-robin model.
        apply_reset();
        pending = '0;
        for (int t = 0; t < 30; t++) begin
            nb      = 4'($urandom_range(0, 15));
            pending = pending | nb;
            if (pending == 4'b0) pending = 4'b1 << $urandom_range(0, 3);
            w       = model_pick(pending, prio_m);
            prio_m  = (w + 1) % NREQ;
            do_txn(pending, pending, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                   $urandom, 2'($urandom_range(0, 2)), int'($urandom_range(0, 3)), $urandom,
                   w, 4'b0);
            pending = pending & ~(4'b1 << w);
        end
        req_i = '0;
        tick();
`else
        // Back-to-back: 0 and 1 both request; 1 is issued in 0's completing ACCESS cycle.
        apply_reset();
        drive_cmds(1'b0, 32'h200, 32'h0, 2'd0);
        req_i = 4'b0011;
        tick();
        chk("b2b_gnt0", 64'(gnt_o), 64'b0001);
        tick();
        tick();
        m_ready    = 1'b1;
        m_data_out = 32'h0000_1111;
        #1;
        chk("b2b_trn",  64'(m_trnsfr), 64'h1);
        chk("b2b_gnt1", 64'(gnt_o), 64'b0010);
        chk("b2b_addr", 64'(m_address), 64'h1200);
        req_i = '0;
        tick();
        chk("b2b_done0", 64'(done_o), 64'b0001);
        chk("b2b_rd0",   64'(rdata_o), 64'h1111);
        chk("b2b_trn2",  64'(m_trnsfr), 64'h0);
        chk("b2b_addr2", 64'(m_address), 64'h1200);
        m_ready = 1'b0;
        tick();
        m_ready    = 1'b1;
        m_data_out = 32'h0000_2222;
        #1;
        chk("b2b_trn3", 64'(m_trnsfr), 64'h0);
        tick();
        chk("b2b_done1", 64'(done_o), 64'b0010);
        chk("b2b_rd1",   64'(rdata_o), 64'h2222);
        m_ready = 1'b0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
